// File: rtl/password_checker.sv
// password_checker: four-digit BCD code entry with timed unlock and lockout, ticked by the 1 Hz divider wave.
module password_checker #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          MAX_TRIES   = 3,
  parameter int          UNLOCK_SEC  = 5,
  parameter int          LOCKOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic       unlocked,
  output logic       lockout,
  output logic       fail,
  output logic [2:0] digits_entered,
  output logic [3:0] tries_left,
  output logic [3:0] timer
);
  localparam logic [1:0] S_ENTRY   = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_UNLOCK  = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);
  logic [1:0]  enter_sync_q, clear_sync_q;
  logic        enter_hist_q, clear_hist_q, clk_div_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  digits_q, digits_d;
  logic [3:0]  tries_q, tries_d, timer_q, timer_d;
  logic        unlocked_q, lockout_q, fail_q, fail_d;
  logic        enter_edge, clear_edge, tick;
  assign enter_edge = enter_sync_q[1] & ~enter_hist_q;
  assign clear_edge = clear_sync_q[1] & ~clear_hist_q;
  // clk_div is generated in this clock domain, so only edge detection is needed
  assign tick = clk_div & ~clk_div_q;
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    digits_d = digits_q;
    tries_d  = tries_q;
    timer_d  = timer_q;
    fail_d   = 1'b0;
    case (state_q)
      S_ENTRY: begin
        if (digits_q == 3'd4) state_d = S_CHECK;
        else if (clear_edge) begin
          entry_d  = '0;
          digits_d = '0;
        end else if (enter_edge && digit <= 4'd9) begin
          entry_d  = {entry_q[11:0], digit};
          digits_d = digits_q + 3'd1;
        end
      end
      S_CHECK: begin
        entry_d  = '0;
        digits_d = '0;
        if (entry_q == CODE) begin
          state_d = S_UNLOCK;
          timer_d = 4'(UNLOCK_SEC);
          tries_d = TRIES_MAX;
        end else begin
          fail_d  = 1'b1;
          tries_d = tries_q - 4'd1;
          state_d = (tries_d == 4'd0) ? S_LOCKOUT : S_ENTRY;
          timer_d = (tries_d == 4'd0) ? 4'(LOCKOUT_SEC) : timer_q;
        end
      end
      S_UNLOCK: begin
        if (clear_edge) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else if (tick) begin
          timer_d = timer_q - 4'd1;
          state_d = (timer_q == 4'd1) ? S_ENTRY : S_UNLOCK;
        end
      end
      default: begin
        if (tick) begin
          timer_d = timer_q - 4'd1;
          state_d = (timer_q == 4'd1) ? S_ENTRY : S_LOCKOUT;
          tries_d = (timer_q == 4'd1) ? TRIES_MAX : tries_q;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    clk_div_q <= clk_div;
    if (rst) begin
      enter_sync_q <= '0;
      clear_sync_q <= '0;
      enter_hist_q <= 1'b0;
      clear_hist_q <= 1'b0;
      state_q      <= S_ENTRY;
      entry_q      <= '0;
      digits_q     <= '0;
      tries_q      <= TRIES_MAX;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      lockout_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      enter_sync_q <= {enter_sync_q[0], enter};
      clear_sync_q <= {clear_sync_q[0], clear};
      enter_hist_q <= enter_sync_q[1];
      clear_hist_q <= clear_sync_q[1];
      state_q      <= state_d;
      entry_q      <= entry_d;
      digits_q     <= digits_d;
      tries_q      <= tries_d;
      timer_q      <= timer_d;
      unlocked_q   <= state_d == S_UNLOCK;
      lockout_q    <= state_d == S_LOCKOUT;
      fail_q       <= fail_d;
    end
  end
  assign unlocked       = unlocked_q;
  assign lockout        = lockout_q;
  assign fail           = fail_q;
  assign digits_entered = digits_q;
  assign tries_left     = tries_q;
  assign timer          = timer_q;
endmodule

// File: tb/tb_password_checker.sv
// tb_password_checker: directed checks of code entry, unlock timing, lockout and reset recovery.
module tb_password_checker;
  logic       clk = 0, rst = 1, clk_div = 0, enter = 0, clear = 0;
  logic [3:0] digit = 0;
  logic       unlocked, lockout, fail;
  logic [2:0] digits_entered;
  logic [3:0] tries_left, timer;
  int         n_tests = 0, n_fail = 0;
  password_checker dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .digit(digit), .enter(enter), .clear(clear),
    .unlocked(unlocked), .lockout(lockout), .fail(fail), .digits_entered(digits_entered),
    .tries_left(tries_left), .timer(timer)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [3:0] d);
    digit = d;
    enter = 1;
    idle(3);
    enter = 0;
  endtask
  task automatic press_clear();
    clear = 1;
    idle(3);
    clear = 0;
  endtask
  task automatic tick();
    clk_div = 0;
    idle(5);
    clk_div = 1;
    idle(1);
  endtask
  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) begin
      press(c[i*4 +: 4]);
      if (i > 0) idle(3);
    end
    idle(2);
  endtask
  task automatic check_reset(input string tag);
    check({tag, " unlocked"}, 16'(unlocked), 0);
    check({tag, " lockout"}, 16'(lockout), 0);
    check({tag, " fail"}, 16'(fail), 0);
    check({tag, " digits"}, 16'(digits_entered), 0);
    check({tag, " tries"}, 16'(tries_left), 3);
    check({tag, " timer"}, 16'(timer), 0);
  endtask
  initial begin
    idle(3);
    check_reset("reset");
    rst = 0;
    idle(2);
    for (int i = 1; i <= 4; i++) begin
      press(4'(i));
      check($sformatf("digits after %0d", i), 16'(digits_entered), 16'(i));
      if (i < 4) idle(3);
    end
    idle(1);
    check("check cycle unlocked", 16'(unlocked), 0);
    idle(1);
    check("unlocked", 16'(unlocked), 1);
    check("unlock timer", 16'(timer), 5);
    check("unlock tries", 16'(tries_left), 3);
    check("unlock digits", 16'(digits_entered), 0);
    idle(3);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("unlock tick %0d timer", i), 16'(timer), 16'(5 - i));
      check($sformatf("unlock tick %0d unlocked", i), 16'(unlocked), (i < 5) ? 16'd1 : 16'd0);
    end
    idle(3);
    for (int a = 1; a <= 3; a++) begin
      enter_code(16'h1235);
      check($sformatf("fail pulse %0d", a), 16'(fail), 1);
      check($sformatf("tries after %0d", a), 16'(tries_left), 16'(3 - a));
      check($sformatf("lockout after %0d", a), 16'(lockout), (a == 3) ? 16'd1 : 16'd0);
      idle(1);
      check($sformatf("fail width %0d", a), 16'(fail), 0);
      idle(3);
    end
    check("lockout timer", 16'(timer), 10);
    press(4'd1);
    idle(3);
    check("lockout ignores enter", 16'(digits_entered), 0);
    press_clear();
    idle(3);
    check("lockout ignores clear", 16'(lockout), 1);
    for (int i = 1; i <= 10; i++) tick();
    check("lockout ends", 16'(lockout), 0);
    check("lockout tries reload", 16'(tries_left), 3);
    check("lockout timer zero", 16'(timer), 0);
    idle(3);
    press(4'd1);
    idle(3);
    press(4'd2);
    check("two digits", 16'(digits_entered), 2);
    idle(3);
    press_clear();
    check("clear digits", 16'(digits_entered), 0);
    idle(3);
    press(4'd1);
    check("digit before combo", 16'(digits_entered), 1);
    idle(3);
    digit = 4'd5;
    enter = 1;
    clear = 1;
    idle(3);
    enter = 0;
    clear = 0;
    check("clear beats enter", 16'(digits_entered), 0);
    idle(3);
    press(4'hA);
    idle(2);
    check("invalid digit", 16'(digits_entered), 0);
    idle(3);
    enter_code(16'h1234);
    check("second unlock", 16'(unlocked), 1);
    tick();
    tick();
    check("timer before clear", 16'(timer), 3);
    press_clear();
    check("clear relocks", 16'(unlocked), 0);
    check("clear timer", 16'(timer), 0);
    idle(3);
    for (int a = 1; a <= 3; a++) begin
      enter_code(16'h9999);
      idle(3);
    end
    check("lockout again", 16'(lockout), 1);
    tick();
    check("lockout tick", 16'(timer), 9);
    rst = 1;
    idle(2);
    check_reset("mid reset");
    rst = 0;
    idle(3);
    check_reset("after release");
    enter_code(16'h1234);
    check("unlock after reset", 16'(unlocked), 1);
    idle(4);
    check("no spurious tick", 16'(timer), 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
